// File: rtl/cluster_pwr_seq_pkg.sv
// Shared types and constants for the cluster power sequencer.
package cluster_pwr_seq_pkg;

    typedef enum logic [2:0] {
        S_OFF,
        S_PWR_UP,
        S_CLK_UP,
        S_RST_UP,
        S_ON,
        S_DRAIN,
        S_RST_DN,
        S_CLK_DN
    } seq_state_e;

    localparam int DEF_PWR_DLY = 16;
    localparam int DEF_CLK_DLY = 4;
    localparam int DEF_RST_DLY = 8;
    localparam int DEF_TIMEOUT = 1024;

    // One spare bit above the largest delay so a loaded value never wraps.
    function automatic int dly_cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/cluster_pwr_seq_if.sv
// Command handshake and cluster boundary signals of the power sequencer.
interface cluster_pwr_seq_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_on_i;
    logic [63:0] cmd_boot_addr_i;
    logic        cmd_byp_i;
    logic        cluster_busy_i;
    logic        cluster_pow_o;
    logic        cluster_byp_o;
    logic        cluster_clk_en_o;
    logic        cluster_rstn_o;
    logic        cluster_fetch_enable_o;
    logic [63:0] cluster_boot_addr_o;
    logic        state_on_o;
    logic        evt_done_o;
    logic        err_timeout_o;

    // Fabric controller / cluster side
    modport master (
        output cmd_valid_i, cmd_on_i, cmd_boot_addr_i, cmd_byp_i, cluster_busy_i,
        input  cmd_ready_o, cluster_pow_o, cluster_byp_o, cluster_clk_en_o,
               cluster_rstn_o, cluster_fetch_enable_o, cluster_boot_addr_o,
               state_on_o, evt_done_o, err_timeout_o
    );

    // Sequencer side
    modport slave (
        input  cmd_valid_i, cmd_on_i, cmd_boot_addr_i, cmd_byp_i, cluster_busy_i,
        output cmd_ready_o, cluster_pow_o, cluster_byp_o, cluster_clk_en_o,
               cluster_rstn_o, cluster_fetch_enable_o, cluster_boot_addr_o,
               state_on_o, evt_done_o, err_timeout_o
    );
endinterface

// File: rtl/cluster_seq_dly_cnt.sv
// Loadable down-counter that holds at zero; zero flag marks the last cycle of a timed state.
module cluster_seq_dly_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    // Load on state entry, otherwise count down and stick at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/cluster_pwr_seq.sv
// Cluster power/clock/reset sequencer.
// Optional drain timeout enabled by defining CLUSTER_SEQ_TIMEOUT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------
// OFF      | cluster unpowered, accepts commands
// PWR_UP   | power on, waiting PWR_DLY before clock enable
// CLK_UP   | clock on, waiting CLK_DLY before reset release
// RST_UP   | reset released, waiting RST_DLY before fetch enable
// ON       | cluster running, accepts commands
// DRAIN    | fetch disabled, waiting for cluster_busy_i to drop
// RST_DN   | reset asserted, clock still on for RST_DLY
// CLK_DN   | clock gated, waiting CLK_DLY before power drop
module cluster_pwr_seq
    import cluster_pwr_seq_pkg::*;
#(
    parameter int PWR_DLY = DEF_PWR_DLY,
    parameter int CLK_DLY = DEF_CLK_DLY,
    parameter int RST_DLY = DEF_RST_DLY,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    cluster_pwr_seq_if.slave   bus
);

    localparam int CW = dly_cnt_width(PWR_DLY, CLK_DLY, RST_DLY, TIMEOUT);

    seq_state_e      state;
    logic            ready_q;
    logic            pow_q;
    logic            byp_q;
    logic            clk_en_q;
    logic            rstn_q;
    logic            fetch_q;
    logic [63:0]     boot_q;
    logic            on_q;
    logic            done_q;

    logic            accept;
    logic            drain_exit;
    logic            cnt_load;
    logic [CW-1:0]   cnt_load_val;
    logic            cnt_zero;
`ifdef CLUSTER_SEQ_TIMEOUT_EN
    logic            drain_timeout;
    logic            err_q;
`endif

    // Handshake and drain exit conditions shared by the FSM and the counter load.
    always_comb begin
        accept     = bus.cmd_valid_i && ready_q;
`ifdef CLUSTER_SEQ_TIMEOUT_EN
        drain_timeout = bus.cluster_busy_i && cnt_zero;
        drain_exit    = !bus.cluster_busy_i || cnt_zero;
`else
        drain_exit    = !bus.cluster_busy_i;
`endif
    end

    // Reload the delay counter on entry to each timed state.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (state)
            S_OFF:    if (accept && bus.cmd_on_i)  begin cnt_load = 1'b1; cnt_load_val = CW'(PWR_DLY - 1); end
            S_PWR_UP: if (cnt_zero)                begin cnt_load = 1'b1; cnt_load_val = CW'(CLK_DLY - 1); end
            S_CLK_UP: if (cnt_zero)                begin cnt_load = 1'b1; cnt_load_val = CW'(RST_DLY - 1); end
            S_ON:     if (accept && !bus.cmd_on_i) begin cnt_load = 1'b1; cnt_load_val = CW'(TIMEOUT - 1); end
            S_DRAIN:  if (drain_exit)              begin cnt_load = 1'b1; cnt_load_val = CW'(RST_DLY - 1); end
            S_RST_DN: if (cnt_zero)                begin cnt_load = 1'b1; cnt_load_val = CW'(CLK_DLY - 1); end
            default:  ;
        endcase
    end

    cluster_seq_dly_cnt #(
        .WIDTH (CW)
    ) u_dly_cnt (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    // Sequencer FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_OFF;
            ready_q  <= 1'b1;
            pow_q    <= 1'b0;
            byp_q    <= 1'b0;
            clk_en_q <= 1'b0;
            rstn_q   <= 1'b0;
            fetch_q  <= 1'b0;
            boot_q   <= '0;
            on_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_OFF: begin
                    if (accept) begin
                        if (bus.cmd_on_i) begin
                            state   <= S_PWR_UP;
                            ready_q <= 1'b0;
                            pow_q   <= 1'b1;
                            boot_q  <= bus.cmd_boot_addr_i;
                            byp_q   <= bus.cmd_byp_i;
                        end else begin
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_PWR_UP: begin
                    if (cnt_zero) begin
                        state    <= S_CLK_UP;
                        clk_en_q <= 1'b1;
                    end
                end
                S_CLK_UP: begin
                    if (cnt_zero) begin
                        state  <= S_RST_UP;
                        rstn_q <= 1'b1;
                    end
                end
                S_RST_UP: begin
                    if (cnt_zero) begin
                        state   <= S_ON;
                        fetch_q <= 1'b1;
                        on_q    <= 1'b1;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
                S_ON: begin
                    if (accept) begin
                        if (!bus.cmd_on_i) begin
                            state   <= S_DRAIN;
                            fetch_q <= 1'b0;
                            on_q    <= 1'b0;
                            ready_q <= 1'b0;
                        end else begin
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_exit) begin
                        state  <= S_RST_DN;
                        rstn_q <= 1'b0;
                    end
                end
                S_RST_DN: begin
                    if (cnt_zero) begin
                        state    <= S_CLK_DN;
                        clk_en_q <= 1'b0;
                    end
                end
                S_CLK_DN: begin
                    if (cnt_zero) begin
                        state   <= S_OFF;
                        pow_q   <= 1'b0;
                        byp_q   <= 1'b0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_OFF;
                end
            endcase
        end
    end

`ifdef CLUSTER_SEQ_TIMEOUT_EN
    // Sticky drain timeout, cleared by the next accepted command.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (state == S_DRAIN && drain_timeout) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err_timeout_o = err_q;
`else
    assign bus.err_timeout_o = 1'b0;
`endif

    assign bus.cmd_ready_o            = ready_q;
    assign bus.cluster_pow_o          = pow_q;
    assign bus.cluster_byp_o          = byp_q;
    assign bus.cluster_clk_en_o       = clk_en_q;
    assign bus.cluster_rstn_o         = rstn_q;
    assign bus.cluster_fetch_enable_o = fetch_q;
    assign bus.cluster_boot_addr_o    = boot_q;
    assign bus.state_on_o             = on_q;
    assign bus.evt_done_o             = done_q;

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// Directed bench for cluster_pwr_seq: vector table plus hand sequences.
// Output vector order: {pow, clk_en, rstn, fetch, ready, done, state_on, byp, err}.
module tb_cluster_pwr_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cluster_pwr_seq_if bus ();

    cluster_pwr_seq #(
        .PWR_DLY (16),
        .CLK_DLY (4),
        .RST_DLY (8),
        .TIMEOUT (32)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        bit          is_cmd;
        bit          on;
        logic [63:0] boot;
        bit          byp;
        bit          busy;
        int          off;
        logic [8:0]  exp;
        logic [63:0] eboot;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   hold_valid = 1'b0;

    function automatic logic [8:0] outs();
        return {bus.cluster_pow_o, bus.cluster_clk_en_o, bus.cluster_rstn_o,
                bus.cluster_fetch_enable_o, bus.cmd_ready_o, bus.evt_done_o,
                bus.state_on_o, bus.cluster_byp_o, bus.err_timeout_o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [8:0] e, input logic [63:0] eb);
        logic [8:0] got;
        got = outs();
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s outputs: got %b expected %b", name, got, e);
        end
        n_cmp++;
        if (bus.cluster_boot_addr_o !== eb) begin
            n_bad++;
            $display("FAIL %s boot_addr: got %h expected %h", name, bus.cluster_boot_addr_o, eb);
        end
    endtask

    task automatic cmd(input bit on, input logic [63:0] boot, input bit byp);
        bus.cmd_valid_i     = 1'b1;
        bus.cmd_on_i        = on;
        bus.cmd_boot_addr_i = boot;
        bus.cmd_byp_i       = byp;
        cyc = 0;
    endtask

    task automatic adv_to(input int t);
        while (cyc < t) begin
            step();
            if (!hold_valid) bus.cmd_valid_i = 1'b0;
            cyc++;
        end
    endtask

    task automatic add(input bit c, input bit on, input logic [63:0] boot, input bit byp,
                       input bit busy, input int off, input logic [8:0] exp, input logic [63:0] eb);
        vec_t v;
        v.is_cmd = c; v.on = on; v.boot = boot; v.byp = byp; v.busy = busy;
        v.off = off; v.exp = exp; v.eboot = eb;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        localparam logic [63:0] B0 = 64'h0000_0000_1C00_8080;
        localparam logic [63:0] B1 = 64'h8000_0000_0000_1000;

        // ON from OFF, boot B0, byp 0
        add(1, 1, B0, 0, 0, 0, 9'b0, 64'h0);
        add(0, 0, 0, 0, 0, 1,  9'b100000000, B0);
        add(0, 0, 0, 0, 0, 16, 9'b100000000, B0);
        add(0, 0, 0, 0, 0, 17, 9'b110000000, B0);
        add(0, 0, 0, 0, 0, 20, 9'b110000000, B0);
        add(0, 0, 0, 0, 0, 21, 9'b111000000, B0);
        add(0, 0, 0, 0, 0, 28, 9'b111000000, B0);
        add(0, 0, 0, 0, 0, 29, 9'b111111100, B0);
        add(0, 0, 0, 0, 0, 30, 9'b111110100, B0);
        // redundant ON with another boot address
        add(1, 1, 64'hDEAD_BEEF_0000_0004, 1, 0, 0, 9'b0, 64'h0);
        add(0, 0, 0, 0, 0, 1,  9'b111111100, B0);
        add(0, 0, 0, 0, 0, 2,  9'b111110100, B0);
        // OFF, busy already low
        add(1, 0, 64'h0, 0, 0, 0, 9'b0, 64'h0);
        add(0, 0, 0, 0, 0, 1,  9'b111000000, B0);
        add(0, 0, 0, 0, 0, 2,  9'b110000000, B0);
        add(0, 0, 0, 0, 0, 9,  9'b110000000, B0);
        add(0, 0, 0, 0, 0, 10, 9'b100000000, B0);
        add(0, 0, 0, 0, 0, 13, 9'b100000000, B0);
        add(0, 0, 0, 0, 0, 14, 9'b000011000, B0);
        add(0, 0, 0, 0, 0, 15, 9'b000010000, B0);
        // redundant OFF
        add(1, 0, 64'h0, 1, 0, 0, 9'b0, 64'h0);
        add(0, 0, 0, 0, 0, 1,  9'b000011000, B0);
        add(0, 0, 0, 0, 0, 2,  9'b000010000, B0);
        // ON with bypass
        add(1, 1, B1, 1, 0, 0, 9'b0, 64'h0);
        add(0, 0, 0, 0, 0, 1,  9'b100000010, B1);
        add(0, 0, 0, 0, 0, 29, 9'b111111110, B1);
        add(0, 0, 0, 0, 0, 30, 9'b111110110, B1);

        bus.cmd_valid_i     = 1'b0;
        bus.cmd_on_i        = 1'b0;
        bus.cmd_boot_addr_i = '0;
        bus.cmd_byp_i       = 1'b0;
        bus.cluster_busy_i  = 1'b0;

        step();
        step();
        rst = 1'b0;
        chk("reset", 9'b000010000, 64'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            bus.cluster_busy_i = tbl[i].busy;
            if (tbl[i].is_cmd) begin
                cmd(tbl[i].on, tbl[i].boot, tbl[i].byp);
            end else begin
                adv_to(tbl[i].off);
                chk($sformatf("tbl[%0d]@%0d", i, tbl[i].off), tbl[i].exp, tbl[i].eboot);
            end
        end

`ifdef CLUSTER_SEQ_TIMEOUT_EN
        // OFF with busy stuck high: timeout after 32 DRAIN cycles
        bus.cluster_busy_i = 1'b1;
        cmd(0, 64'h0, 0);
        adv_to(1);  chk("to_drain",   9'b111000010, B1);
        adv_to(32); chk("to_last",    9'b111000010, B1);
        adv_to(33); chk("to_rst_dn",  9'b110000011, B1);
        adv_to(41); chk("to_clk_dn",  9'b100000011, B1);
        adv_to(45); chk("to_off",     9'b000011001, B1);
        bus.cluster_busy_i = 1'b0;
        cmd(1, 64'h55, 0);
        adv_to(1);  chk("to_clear",   9'b100000000, 64'h55);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("to_reset", 9'b000010000, 64'h0);
`else
        // OFF with busy high for 50 cycles
        bus.cluster_busy_i = 1'b1;
        cmd(0, 64'h0, 0);
        adv_to(1);  chk("busy_drain", 9'b111000010, B1);
        adv_to(50); chk("busy_hold",  9'b111000010, B1);
        bus.cluster_busy_i = 1'b0;
        adv_to(51); chk("busy_rst",   9'b110000010, B1);
        adv_to(58); chk("busy_rst_e", 9'b110000010, B1);
        adv_to(59); chk("busy_clk",   9'b100000010, B1);
        adv_to(62); chk("busy_clk_e", 9'b100000010, B1);
        adv_to(63); chk("busy_off",   9'b000011000, B1);
`endif

        // valid held high through power-up; OFF taken on the first ON cycle
        cmd(1, 64'h1234_5678, 0);
        hold_valid = 1'b1;
        adv_to(1);
        bus.cmd_on_i = 1'b0;
        adv_to(5);  chk("hold_pwr",  9'b100000000, 64'h1234_5678);
        adv_to(29); chk("hold_on",   9'b111111100, 64'h1234_5678);
        hold_valid = 1'b0;
        adv_to(30); chk("hold_drain", 9'b111000000, 64'h1234_5678);
        adv_to(31); chk("hold_rst",   9'b110000000, 64'h1234_5678);
        adv_to(43); chk("hold_off",   9'b000011000, 64'h1234_5678);

        // reset during CLK_UP
        cmd(1, B0, 1);
        adv_to(18); chk("mid_clk_up", 9'b110000010, B0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_reset", 9'b000010000, 64'h0);
        cmd(1, 64'hABCD, 0);
        adv_to(1);  chk("post_reset_on", 9'b100000000, 64'hABCD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
